// File: rtl/chip_checker_platorm_pin_sense_pio.sv
// Avalon-MM input PIO: synchronized, optionally debounced pin sense
// with level, edge-capture and mask registers and a level IRQ.
module chip_checker_platorm_pin_sense_pio #(
  parameter int WIDTH           = 16,
  parameter int DEBOUNCE_CYCLES = 0,
  parameter int EDGE_TYPE       = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int PW =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [WIDTH-1:0] level;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] clr;
  logic             wr;
  logic             unused_wd;

  // Upper write-data bits have no home when WIDTH < 32.
  assign unused_wd = ^writedata;

  assign wr = chipselect & ~write_n;

  // Two-flop synchronizer for the asynchronous pins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= in_port;
      s2 <= s1;
    end
  end

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_nodb
      // Debounce bypassed: level follows the synchronizer.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) level <= '0;
        else          level <= s2;
      end
    end else begin : g_db
      logic [PW-1:0]    pre;
      logic [WIDTH-1:0] samp;
      logic             tick;

      assign tick = (pre == PW'(DEBOUNCE_CYCLES - 1));

      // Sample prescaler, wraps at DEBOUNCE_CYCLES.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)  pre <= '0;
        else if (tick) pre <= '0;
        else           pre <= pre + PW'(1);
      end

      // Accept a bit once two consecutive samples agree.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          samp  <= '0;
          level <= '0;
        end else if (tick) begin
          samp  <= s2;
          level <= (level & (s2 ^ samp)) | (s2 & ~(s2 ^ samp));
        end
      end
    end
  endgenerate

  assign rise = level & ~prev;
  assign fall = ~level & prev;

  generate
    if (EDGE_TYPE == 0) begin : g_rise
      assign edge_det = rise;
    end else if (EDGE_TYPE == 1) begin : g_fall
      assign edge_det = fall;
    end else begin : g_any
      assign edge_det = rise | fall;
    end
  endgenerate

  assign clr = (wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

  // Previous level, edge capture (set beats clear) and mask.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev         <= '0;
      edge_capture <= '0;
      irq_mask     <= '0;
    end else begin
      prev         <= level;
      edge_capture <= (edge_capture & ~clr) | edge_det;
      if (wr && address == 2'd2)
        irq_mask <= writedata[WIDTH-1:0];
    end
  end

  // Read data and IRQ registered every clock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
      irq      <= 1'b0;
    end else begin
      irq <= |(edge_capture & irq_mask);
      unique case (address)
        2'd0:    readdata <= 32'(level);
        2'd2:    readdata <= 32'(irq_mask);
        2'd3:    readdata <= 32'(edge_capture);
        default: readdata <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_chip_checker_platorm_pin_sense_pio.sv
// Directed bench for the pin-sense PIO: default, debounced and
// falling-edge instances share one Avalon bus.
module tb_chip_checker_platorm_pin_sense_pio;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [15:0] in0 = '0;
  logic [15:0] in1 = '0;
  logic [15:0] in2 = '0;
  logic [31:0] rd0;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic        irq0;
  logic        irq1;
  logic        irq2;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  chip_checker_platorm_pin_sense_pio #(
    .WIDTH(16), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(2)
  ) dut0 (
    .clk(clk), .reset_n(reset_n), .address(address),
    .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in0),
    .readdata(rd0), .irq(irq0)
  );

  chip_checker_platorm_pin_sense_pio #(
    .WIDTH(16), .DEBOUNCE_CYCLES(8), .EDGE_TYPE(2)
  ) dut1 (
    .clk(clk), .reset_n(reset_n), .address(address),
    .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in1),
    .readdata(rd1), .irq(irq1)
  );

  chip_checker_platorm_pin_sense_pio #(
    .WIDTH(16), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(1)
  ) dut2 (
    .clk(clk), .reset_n(reset_n), .address(address),
    .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in2),
    .readdata(rd2), .irq(irq2)
  );

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick(1);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a);
    address    = a;
    chipselect = 1'b1;
    tick(1);
    chipselect = 1'b0;
  endtask

  task automatic test_reset;
    in0 = 16'hFFFF;
    reset_n = 1'b0;
    tick(3);
    reset_n = 1'b1;
    tick(1);
    total++;
    if (rd0 !== 32'h0) $display("FAIL reset_data_c1 got %h want %h", rd0, 32'h0);
    else passed++;
    tick(1);
    total++;
    if (rd0 !== 32'h0) $display("FAIL reset_data_c2 got %h want %h", rd0, 32'h0);
    else passed++;
    tick(2);
    total++;
    if (rd0 !== 32'h0000FFFF) $display("FAIL reset_data_c4 got %h want %h", rd0, 32'h0000FFFF);
    else passed++;
    rd(2'd3);
    total++;
    if (rd0 !== 32'h0000FFFF) $display("FAIL reset_edge got %h want %h", rd0, 32'h0000FFFF);
    else passed++;
    total++;
    if (irq0 !== 1'b0) $display("FAIL reset_irq got %b want %b", irq0, 1'b0);
    else passed++;
    in0 = 16'h0000;
    tick(6);
  endtask

  task automatic test_edge_irq;
    int n;
    wr(2'd2, 32'h1);
    wr(2'd3, 32'hFFFF);
    rd(2'd3);
    total++;
    if (rd0 !== 32'h0) $display("FAIL edge_cleared got %h want %h", rd0, 32'h0);
    else passed++;
    in0[0] = 1'b1;
    n = 0;
    while (n < 5 && irq0 !== 1'b1) begin
      tick(1);
      n++;
    end
    total++;
    if (irq0 !== 1'b1) $display("FAIL irq_rise got %b want %b", irq0, 1'b1);
    else passed++;
    rd(2'd3);
    total++;
    if (rd0 !== 32'h1) $display("FAIL edge_bit0 got %h want %h", rd0, 32'h1);
    else passed++;
    wr(2'd3, 32'h1);
    total++;
    if (irq0 !== 1'b1) $display("FAIL irq_hold got %b want %b", irq0, 1'b1);
    else passed++;
    tick(1);
    total++;
    if (irq0 !== 1'b0) $display("FAIL irq_clear got %b want %b", irq0, 1'b0);
    else passed++;
  endtask

  task automatic test_collision;
    in0[3] = 1'b1;
    tick(3);
    wr(2'd3, 32'h8);
    rd(2'd3);
    total++;
    if (rd0 !== 32'h8) $display("FAIL collide_set got %h want %h", rd0, 32'h8);
    else passed++;
    wr(2'd3, 32'h8);
    rd(2'd3);
    total++;
    if (rd0 !== 32'h0) $display("FAIL w1c_clear got %h want %h", rd0, 32'h0);
    else passed++;
  endtask

  task automatic test_debounce;
    bit found;
    wr(2'd3, 32'hFFFF);
    in1[2] = 1'b1;
    tick(5);
    in1[2] = 1'b0;
    tick(30);
    rd(2'd0);
    total++;
    if (rd1 !== 32'h0) $display("FAIL glitch_data got %h want %h", rd1, 32'h0);
    else passed++;
    rd(2'd3);
    total++;
    if (rd1 !== 32'h0) $display("FAIL glitch_edge got %h want %h", rd1, 32'h0);
    else passed++;
    in1[2] = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 19 && !found; i++) begin
      rd(2'd0);
      if (rd1[2] === 1'b1) found = 1'b1;
    end
    total++;
    if (!found) $display("FAIL db_rise got %h want %h", rd1, 32'h4);
    else passed++;
    tick(25);
    in1[2] = 1'b0;
    rd(2'd3);
    total++;
    if (rd1 !== 32'h4) $display("FAIL db_edge got %h want %h", rd1, 32'h4);
    else passed++;
    tick(30);
  endtask

  task automatic test_falling;
    wr(2'd3, 32'hFFFF);
    in2[4] = 1'b1;
    tick(10);
    rd(2'd3);
    total++;
    if (rd2 !== 32'h0) $display("FAIL fall_no_rise got %h want %h", rd2, 32'h0);
    else passed++;
    in2[4] = 1'b0;
    tick(10);
    rd(2'd3);
    total++;
    if (rd2 !== 32'h10) $display("FAIL fall_edge got %h want %h", rd2, 32'h10);
    else passed++;
  endtask

  task automatic test_regmap;
    wr(2'd1, 32'hDEADBEEF);
    rd(2'd1);
    total++;
    if (rd0 !== 32'h0) $display("FAIL addr1_zero got %h want %h", rd0, 32'h0);
    else passed++;
    wr(2'd2, 32'hFFFF1234);
    rd(2'd2);
    total++;
    if (rd0 !== 32'h1234) $display("FAIL mask_rd got %h want %h", rd0, 32'h1234);
    else passed++;
    address = 2'd0;
    #1;
    total++;
    if (rd0 !== 32'h1234) $display("FAIL lat_hold got %h want %h", rd0, 32'h1234);
    else passed++;
    tick(1);
    total++;
    if (rd0 !== 32'h9) $display("FAIL lat_data got %h want %h", rd0, 32'h9);
    else passed++;
  endtask

  initial begin
    test_reset;
    test_edge_irq;
    test_collision;
    test_debounce;
    test_falling;
    test_regmap;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
